// File: rtl/synth_pkg.sv
// Shared widths and FSM state type for the wavetable interpolator.
package synth_pkg;

  localparam int unsigned WT_ADDR_W = 12;
  localparam int unsigned WT_FRAC_W = 16;
  localparam int unsigned SAMPLE_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR1 = 3'd1,
    ST_CAP0  = 3'd2,
    ST_CAP1  = 3'd3,
    ST_CALC  = 3'd4
  } wt_state_e;

endpackage

// File: rtl/wavetable_interp_if.sv
// Request, ROM and result signals of the wavetable interpolator.
interface wavetable_interp_if;
  import synth_pkg::*;

  logic                        Enable;
  logic [WT_ADDR_W-1:0]        wavetableAddr;
  logic [WT_FRAC_W-1:0]        interp;
  logic [WT_ADDR_W-1:0]        memAddr;
  logic signed [SAMPLE_W-1:0]  memData;
  logic signed [SAMPLE_W-1:0]  sample;
  logic                        sampleValid;
  logic                        busy;
  logic                        overrun;

  modport master (
    output Enable, wavetableAddr, interp, memData,
    input  memAddr, sample, sampleValid, busy, overrun
  );

  modport slave (
    input  Enable, wavetableAddr, interp, memData,
    output memAddr, sample, sampleValid, busy, overrun
  );

endinterface

// File: rtl/interp_lerp.sv
// Combinational linear interpolation s0 + ((s1 - s0) * frac) >>> 16.
// Only built when WT_LINEAR_INTERP_EN is defined.
`ifdef WT_LINEAR_INTERP_EN
module interp_lerp
  import synth_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0]  s0,
  input  logic signed [SAMPLE_W-1:0]  s1,
  input  logic        [WT_FRAC_W-1:0] frac,
  output logic signed [SAMPLE_W-1:0]  result
);
  localparam int unsigned DIFF_W = SAMPLE_W + 1;
  localparam int unsigned PROD_W = 2 * DIFF_W;

  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] prod;

  assign diff = DIFF_W'(s1) - DIFF_W'(s0);
  // frac is zero-extended so it stays non-negative in the signed product
  assign prod = PROD_W'(diff) * PROD_W'($signed({1'b0, frac}));
  // The result always lies between s0 and s1, so truncation cannot overflow
  assign result = SAMPLE_W'(PROD_W'(s0) + (prod >>> WT_FRAC_W));

endmodule
`endif

// File: rtl/wavetable_interp.sv
// Two-point wavetable reader: fetches table[addr], table[addr+1] and interpolates.
// Define WT_LINEAR_INTERP_EN for linear interpolation; otherwise sample = table[addr].
module wavetable_interp
  import synth_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  wavetable_interp_if.slave  bus
);

  wt_state_e                  state_q, state_d;
  logic [WT_ADDR_W-1:0]       addr_q, addr_d;
  logic [WT_ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic signed [SAMPLE_W-1:0] s0_q, s0_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;
  logic signed [SAMPLE_W-1:0] calc_res;

`ifdef WT_LINEAR_INTERP_EN
  logic [WT_FRAC_W-1:0]       frac_q, frac_d;
  logic signed [SAMPLE_W-1:0] s1_q, s1_d;

  interp_lerp u_lerp (
    .s0     (s0_q),
    .s1     (s1_q),
    .frac   (frac_q),
    .result (calc_res)
  );
`else
  assign calc_res = s0_q;
`endif

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      s0_q       <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef WT_LINEAR_INTERP_EN
      frac_q     <= '0;
      s1_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      s0_q       <= s0_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
`ifdef WT_LINEAR_INTERP_EN
      frac_q     <= frac_d;
      s1_q       <= s1_d;
`endif
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    s0_d       = s0_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q;
`ifdef WT_LINEAR_INTERP_EN
    frac_d     = frac_q;
    s1_d       = s1_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Enable) begin
          addr_d     = bus.wavetableAddr;
          mem_addr_d = bus.wavetableAddr;
`ifdef WT_LINEAR_INTERP_EN
          frac_d     = bus.interp;
`endif
          state_d    = ST_ADDR1;
        end
      end
      ST_ADDR1: begin
        // Natural WT_ADDR_W-bit wrap takes the last entry back to 0
        mem_addr_d = addr_q + WT_ADDR_W'(1);
        state_d    = ST_CAP0;
      end
      ST_CAP0: begin
        s0_d    = bus.memData;
        state_d = ST_CAP1;
      end
      ST_CAP1: begin
`ifdef WT_LINEAR_INTERP_EN
        s1_d    = bus.memData;
`endif
        state_d = ST_CALC;
      end
      ST_CALC: begin
        sample_d = calc_res;
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A request arriving mid-operation is dropped and flagged until reset
    if (bus.Enable && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.memAddr     = mem_addr_q;
  assign bus.sample      = sample_q;
  assign bus.sampleValid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_wavetable_interp.sv
// Directed and random checks of wavetable_interp against a floor-division reference.
module tb_wavetable_interp;
  import synth_pkg::*;

`ifdef WT_LINEAR_INTERP_EN
  localparam bit LERP = 1'b1;
`else
  localparam bit LERP = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  wavetable_interp_if bus ();

  wavetable_interp dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Synchronous ROM: data for the registered address appears one cycle later
  logic signed [15:0] rom [4096];
  always @(posedge Clk) bus.memData <= rom[bus.memAddr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: t0 + floor((t1 - t0) * frac / 65536)
  function automatic longint ref_sample(input longint t0, input longint t1, input longint frac);
    longint p, q;
    p = (t1 - t0) * frac;
    q = p / 65536;
    if ((p < 0) && ((p % 65536) != 0)) q = q - 1;
    return LERP ? (t0 + q) : t0;
  endfunction

  task automatic do_op(input logic [11:0] a, input logic [15:0] f, input string tag);
    logic [11:0] a1;
    longint      exp_s;
    a1    = a + 12'd1;
    exp_s = ref_sample(longint'(rom[a]), longint'(rom[a1]), longint'(f));
    Reset = 1'b0;
    bus.Enable = 1'b1;
    bus.wavetableAddr = a;
    bus.interp = f;
    @(posedge Clk); #1;
    bus.Enable = 1'b0;
    bus.wavetableAddr = 12'($urandom);
    bus.interp = 16'($urandom);
    chk({tag, "_addr0"}, 64'(bus.memAddr), 64'(a));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
    chk({tag, "_valid0"}, 64'(bus.sampleValid), 64'(0));
    for (int c = 1; c <= 5; c++) begin
      @(posedge Clk); #1;
      if (c == 1) chk({tag, "_addr1"}, 64'(bus.memAddr), 64'(a1));
      if (c == 4) begin
        chk({tag, "_valid"}, 64'(bus.sampleValid), 64'(1));
        chk({tag, "_sample"}, 64'(bus.sample), 64'(exp_s));
        chk({tag, "_idle"}, 64'(bus.busy), 64'(0));
      end else begin
        chk({tag, "_novalid"}, 64'(bus.sampleValid), 64'(0));
      end
      if (c == 5) chk({tag, "_hold"}, 64'(bus.sample), 64'(exp_s));
    end
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    bus.Enable = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  // Second Enable arrives 'gap' edges after the accepted one and must be dropped
  task automatic overrun_test(input int gap, input string tag);
    logic [11:0] a;
    longint      exp_s;
    int          pulses;
    logic signed [15:0] got;
    apply_reset();
    chk({tag, "_clr"}, 64'(bus.overrun), 64'(0));
    a = 12'($urandom);
    exp_s = ref_sample(longint'(rom[a]), longint'(rom[12'(a + 12'd1)]), longint'(16'h3000));
    pulses = 0;
    got = '0;
    bus.Enable = 1'b1;
    bus.wavetableAddr = a;
    bus.interp = 16'h3000;
    @(posedge Clk); #1;
    for (int c = 1; c <= 8; c++) begin
      bus.Enable = (c == gap);
      bus.wavetableAddr = 12'($urandom);
      bus.interp = 16'($urandom);
      @(posedge Clk); #1;
      bus.Enable = 1'b0;
      if (bus.sampleValid) begin
        pulses++;
        got = bus.sample;
      end
    end
    chk({tag, "_pulses"}, 64'(pulses), 64'(1));
    chk({tag, "_sample"}, 64'(got), 64'(exp_s));
    chk({tag, "_flag"}, 64'(bus.overrun), 64'(1));
    do_op(12'($urandom), 16'($urandom), {tag, "_after"});
    chk({tag, "_sticky"}, 64'(bus.overrun), 64'(1));
    apply_reset();
    chk({tag, "_rstclr"}, 64'(bus.overrun), 64'(0));
  endtask

  initial begin
    logic [11:0] ra;
    for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
    rom[100]  = 16'sd1000;
    rom[101]  = 16'sd2000;
    rom[4095] = 16'sd100;
    rom[0]    = -16'sd100;
    rom[200]  = 16'sd0;
    rom[201]  = -16'sd1;

    // Reset wins over a simultaneous Enable
    Reset = 1'b1;
    bus.Enable = 1'b1;
    bus.wavetableAddr = 12'd55;
    bus.interp = 16'h1234;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rst_memaddr", 64'(bus.memAddr), 64'(0));
    chk("rst_sample", 64'(bus.sample), 64'(0));
    chk("rst_valid", 64'(bus.sampleValid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_overrun", 64'(bus.overrun), 64'(0));
    bus.Enable = 1'b0;
    Reset = 1'b0;
    @(posedge Clk); #1;

    do_op(12'd100, 16'h8000, "basic");
    chk("basic_const", 64'(bus.sample), 64'(LERP ? 1500 : 1000));
    do_op(12'd4095, 16'h4000, "wrap");
    chk("wrap_const", 64'(bus.sample), 64'(LERP ? 50 : 100));
    do_op(12'd200, 16'h8000, "negrnd");
    chk("negrnd_const", 64'(bus.sample), 64'(LERP ? -1 : 0));
    ra = 12'($urandom);
    do_op(ra, 16'h0000, "frac0");
    chk("frac0_exact", 64'(bus.sample), 64'(rom[ra]));

    overrun_test(2, "ovr_cap0");
    overrun_test(4, "ovr_calc");

    // Reset while in CAP1 aborts the operation
    do_op(12'd100, 16'h8000, "pre_abort");
    bus.Enable = 1'b1;
    bus.wavetableAddr = 12'd300;
    bus.interp = 16'h7777;
    @(posedge Clk); #1;
    bus.Enable = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("abort_valid", 64'(bus.sampleValid), 64'(0));
    chk("abort_sample", 64'(bus.sample), 64'(0));
    chk("abort_memaddr", 64'(bus.memAddr), 64'(0));
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_overrun", 64'(bus.overrun), 64'(0));
    do_op(12'd4095, 16'h4000, "post_abort");

    for (int i = 0; i < 25; i++) begin
      do_op(12'($urandom), 16'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wavetable_interp.md
WAVETABLE_INTERP -- requirements
Module: wavetable_interp

Interface
REQ-001 SHALL have port Clk, input, 1, single system clock; all logic on posedge Clk.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Enable, input, 1, sample request strobe, sampled on posedge Clk.
REQ-004 SHALL have port wavetableAddr, input, 12, integer table index from the upstream phase accumulator.
REQ-005 SHALL have port interp, input, 16, unsigned fractional position between wavetableAddr and wavetableAddr+1.
REQ-006 SHALL have port memAddr, output, 12, registered read address to the synchronous wavetable ROM.
REQ-007 SHALL have port memData, input, 16, signed ROM read data, valid one cycle after memAddr is registered.
REQ-008 SHALL have port sample, output, 16, signed interpolated sample, registered.
REQ-009 SHALL have port sampleValid, output, 1, one-cycle pulse marking a new sample value.
REQ-010 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 SHALL have port overrun, output, 1, sticky flag for an Enable dropped while busy.

Function
REQ-012 SHALL implement FSM IDLE -> ADDR1 -> CAP0 -> CAP1 -> CALC -> IDLE, one cycle per state, no stalls.
REQ-013 In IDLE with Enable=1: latch wavetableAddr and interp, memAddr <= wavetableAddr, go to ADDR1.
REQ-014 In ADDR1: memAddr <= latched address + 1, modulo 4096 (4095 wraps to 0).
REQ-015 In CAP0: s0 <= memData; in CAP1: s1 <= memData.
REQ-016 In CALC: sample <= s0 + ((s1 - s0) * {0,frac}) >>> 16.
REQ-017 In CALC: sampleValid <= 1; sampleValid SHALL be 0 in all other cycles.
REQ-018 Difference SHALL be computed at 17-bit signed width and the product at 34-bit signed width.
REQ-019 The shift SHALL be arithmetic, truncating toward minus infinity.
REQ-020 The result lies between s0 and s1 and SHALL never saturate.
REQ-021 Latency: sampleValid SHALL be high in the fifth cycle after the Enable-accepting edge; minimum accepted Enable spacing is 5 cycles.
REQ-022 Enable in any non-IDLE state, including CALC, SHALL be ignored: latched inputs unchanged, overrun <= 1.
REQ-023 overrun SHALL remain set until Reset.
REQ-024 sample SHALL hold its value between sampleValid pulses.
REQ-025 Input changes outside the Enable-accepting edge SHALL have no effect.

Reset
REQ-026 Reset SHALL force state IDLE and set memAddr, sample, latched address/frac, s0 and s1 to 0.
REQ-027 Reset SHALL set sampleValid, busy and overrun to 0.
REQ-028 Reset SHALL take priority over Enable on the same edge.
REQ-029 Reset mid-operation SHALL abort it with no sampleValid pulse.

Configuration
REQ-030 Macro WT_LINEAR_INTERP_EN defined: behaviour as REQ-016.
REQ-031 Macro WT_LINEAR_INTERP_EN undefined: the multiplier and s1 register SHALL be omitted and CALC SHALL output sample <= s0.
REQ-032 With the macro undefined, FSM timing, memAddr sequence, latency and handshake SHALL be identical to the defined case.

Structure
REQ-033 Shared package synth_pkg SHALL hold WT_ADDR_W=12, WT_FRAC_W=16, SAMPLE_W=16 and the FSM state enum type.
REQ-034 Lerp arithmetic SHALL be a combinational sub-module interp_lerp (s0, s1, frac -> result), instantiated only under WT_LINEAR_INTERP_EN.

Verification
REQ-035 Basic: table[100]=1000, table[101]=2000, addr=100, frac=0x8000 -> sample=1500, sampleValid 5 cycles after Enable.
REQ-036 Wrap: table[4095]=100, table[0]=-100, addr=4095, frac=0x4000 -> memAddr sequence 4095 then 0; sample=50.
REQ-037 Negative rounding: s0=0, s1=-1, frac=0x8000 -> sample=-1; frac=0x0000 with any table values -> sample=s0 exactly.
REQ-038 Overrun: Enable pulses 2 cycles apart -> only the first produces sampleValid; overrun=1 and held until Reset.
REQ-039 Reset mid-op: Reset asserted in CAP1 -> no sampleValid; all outputs 0 the next cycle; a new Enable is accepted immediately after.
REQ-040 Macro off: scenario REQ-035 -> sample=1000 with identical latency.
